// File: rtl/onehot_encoder_stream_if.sv
// Stream bundle for the one-hot encoder: input word handshake plus encoded result handshake.
// The slave modport is the encoder side; the master modport is the producer/consumer side.
interface onehot_encoder_stream_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CODE_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic              out_zero;
    logic              out_multi;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_code, out_zero, out_multi
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_code, out_zero, out_multi
    );
endinterface

// File: rtl/onehot_encoder_stream.sv
// Streaming 8-to-3 priority encoder with zero/multi-hot flags, a saturating malformed-word
// counter and a 2-entry (output register + skid) buffer for full throughput under backpressure.
module onehot_encoder_stream #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CODE_W = 3,
    parameter int unsigned ERRC_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    onehot_encoder_stream_if.slave     bus,
    input  logic                       clr_err,
    output logic [ERRC_W-1:0]          err_count
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              in_rdy;
    logic              accept;
    logic              transfer;
    logic              load_out;
    logic              load_skid;
    logic              from_skid;

    logic [CODE_W-1:0] enc_code;
    logic              enc_zero;
    logic              enc_multi;

    logic [CODE_W-1:0] out_code_q;
    logic              out_zero_q;
    logic              out_multi_q;
    logic [CODE_W-1:0] skid_code;
    logic              skid_zero;
    logic              skid_multi;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_rdy        = (state != FULL);
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_code  = out_code_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_multi = out_multi_q;

    assign accept   = bus.in_valid & in_rdy;
    assign transfer = (state != EMPTY) & bus.out_ready;

    // Ascending scan so the last (highest) set bit wins.
    always_comb begin
        enc_code = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (bus.in_data[i]) begin
                enc_code = i[CODE_W-1:0];
            end
        end
        enc_zero  = (bus.in_data == '0);
        enc_multi = ((bus.in_data & (bus.in_data - DATA_W'(1))) != '0);
    end

    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_out  = 1'b1;
                end
            end
            ONE: begin
                if (accept && transfer) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (transfer) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (transfer) begin
                    state_nxt = ONE;
                    load_out  = 1'b1;
                    from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_code_q  <= '0;
            out_zero_q  <= 1'b0;
            out_multi_q <= 1'b0;
        end else if (load_out) begin
            if (from_skid) begin
                out_code_q  <= skid_code;
                out_zero_q  <= skid_zero;
                out_multi_q <= skid_multi;
            end else begin
                out_code_q  <= enc_code;
                out_zero_q  <= enc_zero;
                out_multi_q <= enc_multi;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_code  <= '0;
            skid_zero  <= 1'b0;
            skid_multi <= 1'b0;
        end else if (load_skid) begin
            skid_code  <= enc_code;
            skid_zero  <= enc_zero;
            skid_multi <= enc_multi;
        end
    end

    // Counted at accept time; clear beats a simultaneous increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (clr_err) begin
            err_count <= '0;
        end else if (accept && (enc_zero || enc_multi) && (err_count != '1)) begin
            err_count <= err_count + ERRC_W'(1);
        end
    end
endmodule
